// File: rtl/cpu_seg_pkg.sv
// Shared defaults and response payload type for the segment address translator.
package cpu_seg_pkg;

  localparam int unsigned DEFAULT_OFFSET_W  = 16;
  localparam int unsigned DEFAULT_SEG_SHIFT = 4;
  localparam int unsigned DEFAULT_PADDR_W   = DEFAULT_OFFSET_W + DEFAULT_SEG_SHIFT;

  localparam int unsigned            FAULT_CNT_W   = 8;
  localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [DEFAULT_PADDR_W-1:0] paddr;
    logic                       fault;
  } rsp_t;

endpackage

// File: rtl/segment_address_translator_if.sv
// Request/response handshake bundle between a translation requester and the translator.
interface segment_address_translator_if
  import cpu_seg_pkg::*;
#(
  parameter int unsigned OFFSET_W = DEFAULT_OFFSET_W,
  parameter int unsigned PADDR_W  = DEFAULT_PADDR_W
);

  logic                req_valid;
  logic                req_ready;
  logic [OFFSET_W-1:0] req_offset;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [PADDR_W-1:0]  rsp_paddr;
  logic                rsp_fault;

  modport master (
    output req_valid, req_offset, rsp_ready,
    input  req_ready, rsp_valid, rsp_paddr, rsp_fault
  );

  modport slave (
    input  req_valid, req_offset, rsp_ready,
    output req_ready, rsp_valid, rsp_paddr, rsp_fault
  );

endinterface

// File: rtl/pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its content leaves this cycle.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_c_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_c_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_c_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/segment_address_translator.sv
// Two-stage segment:offset to physical address translator with fault counter.
// Optional limit check enabled by defining SEG_LIMIT_CHECK_EN.
module segment_address_translator
  import cpu_seg_pkg::*;
#(
  parameter int unsigned OFFSET_W  = DEFAULT_OFFSET_W,
  parameter int unsigned SEG_SHIFT = DEFAULT_SEG_SHIFT,
  parameter int unsigned PADDR_W   = DEFAULT_PADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OFFSET_W-1:0]    dsr_data_out,
  input  logic [OFFSET_W-1:0]    seg_limit,
  output logic [FAULT_CNT_W-1:0] fault_count,
  segment_address_translator_if.slave bus
);

`ifdef SEG_LIMIT_CHECK_EN
  localparam int unsigned S1_W = 3 * OFFSET_W;
`else
  localparam int unsigned S1_W = 2 * OFFSET_W;
`endif
  localparam int unsigned S2_W = PADDR_W + 1;

  logic [S1_W-1:0]     s1_in, s1_data;
  logic [S2_W-1:0]     s2_in, s2_data;
  logic                s1_in_ready, s1_valid;
  logic                s2_in_ready, s2_valid;
  logic [OFFSET_W-1:0] s1_offset, s1_base;
  logic [PADDR_W-1:0]  s1_paddr;
  logic                s1_fault;

  // S1 holds the raw operands sampled at acceptance; the add happens on its output.
`ifdef SEG_LIMIT_CHECK_EN
  logic [OFFSET_W-1:0] s1_limit;

  assign s1_in    = {seg_limit, dsr_data_out, bus.req_offset};
  assign s1_limit = s1_data[3*OFFSET_W-1:2*OFFSET_W];
  assign s1_fault = s1_offset > s1_limit;
`else
  logic unused_seg_limit;

  assign s1_in            = {dsr_data_out, bus.req_offset};
  assign unused_seg_limit = ^seg_limit;
  assign s1_fault         = 1'b0;
`endif

  assign s1_offset = s1_data[OFFSET_W-1:0];
  assign s1_base   = s1_data[2*OFFSET_W-1:OFFSET_W];
  assign s1_paddr  = PADDR_W'({s1_base, {SEG_SHIFT{1'b0}}}) + PADDR_W'(s1_offset);
  assign s2_in     = {s1_paddr, s1_fault};

  pipe_stage #(.W(S1_W)) u_s1 (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (bus.req_valid),
    .in_ready_c_o (s1_in_ready),
    .in_data_i    (s1_in),
    .out_valid_o  (s1_valid),
    .out_ready_i  (s2_in_ready),
    .out_data_o   (s1_data)
  );

  pipe_stage #(.W(S2_W)) u_s2 (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (s1_valid),
    .in_ready_c_o (s2_in_ready),
    .in_data_i    (s2_in),
    .out_valid_o  (s2_valid),
    .out_ready_i  (bus.rsp_ready),
    .out_data_o   (s2_data)
  );

  // Held low during reset so nothing is offered as accepted while the stages clear.
  assign bus.req_ready = s1_in_ready & reset;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_paddr = s2_data[S2_W-1:1];
  assign bus.rsp_fault = s2_data[0];

  logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (s2_valid && bus.rsp_ready && s2_data[0] && (fault_cnt_q != FAULT_CNT_MAX)) begin
      fault_cnt_d = fault_cnt_q + FAULT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fault_count = fault_cnt_q;

endmodule

// File: tb/tb_segment_address_translator.sv
// Randomized and directed bench for segment_address_translator against a transaction-level model.
module tb_segment_address_translator;
  import cpu_seg_pkg::*;

`ifdef SEG_LIMIT_CHECK_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif
  localparam logic [15:0] LIM_OPEN = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dsr_data_out;
  logic [15:0] seg_limit;
  logic [7:0]  fault_count;

  segment_address_translator_if #(.OFFSET_W(16), .PADDR_W(20)) bus_if ();

  segment_address_translator dut (
    .clk          (clk),
    .reset        (reset),
    .dsr_data_out (dsr_data_out),
    .seg_limit    (seg_limit),
    .fault_count  (fault_count),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    rsp_t rsp;
    int   acc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned fc_exp   = 0;
  bit          rst_prev = 1'b1;
  bit          rst_next = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference translation: base*16 + offset modulo 2^20, fault when offset exceeds limit.
  function automatic rsp_t ref_xlate(input logic [15:0] base, input logic [15:0] off,
                                     input logic [15:0] lim);
    rsp_t        r;
    int unsigned b = base;
    int unsigned o = off;
    int unsigned l = lim;
    int unsigned sum = (b * 16 + o) % 32'h0010_0000;
    r.paddr = 20'(sum);
    r.fault = LIMIT_ON && (o > l);
    return r;
  endfunction

  // Compare DUT against the model for the upcoming edge, then advance the model past it.
  task automatic step();
    int   n = exp_q.size();
    bit   rv_exp, rr_exp, acc, cons;
    exp_t e;
    if (!reset) begin
      check("req_ready_in_reset", bus_if.req_ready, 0);
      if (rst_prev) begin
        check("rsp_valid_in_reset", bus_if.rsp_valid, 0);
        check("fault_count_in_reset", fault_count, 0);
        check("rsp_paddr_in_reset", bus_if.rsp_paddr, 0);
      end
      exp_q.delete();
      fc_exp   = 0;
      rst_prev = 1'b1;
    end else begin
      rv_exp = (n == 2) || (n == 1 && (cyc - exp_q[0].acc) >= 2);
      rr_exp = (n < 2) || bus_if.rsp_ready;
      check("req_ready", bus_if.req_ready, rr_exp);
      check("rsp_valid", bus_if.rsp_valid, rv_exp);
      check("fault_count", fault_count, fc_exp);
      if (rv_exp) begin
        check("rsp_paddr", bus_if.rsp_paddr, exp_q[0].rsp.paddr);
        check("rsp_fault", bus_if.rsp_fault, exp_q[0].rsp.fault);
      end
      cons = rv_exp && bus_if.rsp_ready;
      acc  = bus_if.req_valid && rr_exp;
      if (cons) begin
        if (exp_q[0].rsp.fault && fc_exp < 255) fc_exp++;
        void'(exp_q.pop_front());
      end
      if (acc) begin
        e.rsp = ref_xlate(dsr_data_out, bus_if.req_offset, seg_limit);
        e.acc = cyc;
        exp_q.push_back(e);
      end
      rst_prev = 1'b0;
    end
    cyc++;
  endtask

  task automatic drive(input bit v, input logic [15:0] off, input logic [15:0] base,
                       input logic [15:0] lim, input bit rr);
    @(negedge clk);
    reset             = rst_next;
    bus_if.req_valid  = v;
    bus_if.req_offset = off;
    dsr_data_out      = base;
    seg_limit         = lim;
    bus_if.rsp_ready  = rr;
    #1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r_off, r_lim;
    reset             = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_offset = '0;
    bus_if.rsp_ready  = 1'b0;
    dsr_data_out      = '0;
    seg_limit         = LIM_OPEN;

    rst_next = 1'b0;
    drive(0, 16'h0, 16'h0, LIM_OPEN, 1);
    drive(0, 16'h0, 16'h0, LIM_OPEN, 1);
    rst_next = 1'b1;
    drive(0, 16'h0, 16'h0, LIM_OPEN, 1);
    check("ready_after_reset", bus_if.req_ready, 1);

    // Latency, DSR update after acceptance, and the follow-up request.
    drive(1, 16'h0012, 16'h3000, LIM_OPEN, 1);
    drive(0, 16'h0000, 16'h5800, LIM_OPEN, 1);
    drive(0, 16'h0000, 16'h5800, LIM_OPEN, 1);
    check("lat2_valid", bus_if.rsp_valid, 1);
    check("paddr_30012", bus_if.rsp_paddr, 20'h30012);
    drive(1, 16'h0000, 16'h5800, LIM_OPEN, 1);
    drive(0, 16'h0000, 16'h5800, LIM_OPEN, 1);
    drive(0, 16'h0000, 16'h5800, LIM_OPEN, 1);
    check("paddr_58000", bus_if.rsp_paddr, 20'h58000);

    // Silent wrap of the physical address.
    drive(1, 16'h0020, 16'hFFFF, LIM_OPEN, 1);
    drive(0, 16'h0000, 16'hFFFF, LIM_OPEN, 1);
    drive(0, 16'h0000, 16'hFFFF, LIM_OPEN, 1);
    check("paddr_wrap", bus_if.rsp_paddr, 20'h00010);
    check("fault_wrap", bus_if.rsp_fault, 0);

    // Back-pressure: two fill the pipe, the third waits until the consumer resumes.
    drive(1, 16'h0101, 16'h1000, LIM_OPEN, 0);
    drive(1, 16'h0202, 16'h1000, LIM_OPEN, 0);
    drive(1, 16'h0303, 16'h1000, LIM_OPEN, 0);
    check("third_waits", bus_if.req_ready, 0);
    drive(1, 16'h0303, 16'h1000, LIM_OPEN, 0);
    check("held_paddr", bus_if.rsp_paddr, 20'h10101);
    drive(1, 16'h0303, 16'h1000, LIM_OPEN, 1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(0, 16'h0, 16'h1000, LIM_OPEN, 1);

`ifdef SEG_LIMIT_CHECK_EN
    drive(1, 16'h0100, 16'h2000, 16'h00FF, 1);
    drive(1, 16'h00FF, 16'h2000, 16'h00FF, 1);
    drive(0, 16'h0000, 16'h2000, 16'h00FF, 1);
    check("limit_fault", bus_if.rsp_fault, 1);
    check("limit_paddr", bus_if.rsp_paddr, 20'h20100);
    drive(0, 16'h0000, 16'h2000, 16'h00FF, 1);
    check("limit_edge_ok", bus_if.rsp_fault, 0);
    check("fault_count_1", fault_count, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      r_off = 16'($urandom);
      r_lim = ($urandom_range(0, 7) == 0) ? r_off : 16'($urandom);
      drive(1'($urandom_range(0, 1)), r_off, 16'($urandom), r_lim, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(0, 16'h0, 16'h0, LIM_OPEN, 1);
`ifdef SEG_LIMIT_CHECK_EN
    check("fault_count_sat", fault_count, 8'hFF);
`endif

    // Reset with the pipe full must drop everything in flight.
    drive(1, 16'h0aaa, 16'h4000, LIM_OPEN, 0);
    drive(1, 16'h0bbb, 16'h4000, LIM_OPEN, 0);
    drive(1, 16'h0ccc, 16'h4000, LIM_OPEN, 0);
    rst_next = 1'b0;
    drive(0, 16'h0, 16'h0, LIM_OPEN, 1);
    rst_next = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 16'h0, 16'h0, LIM_OPEN, 1);
    check("no_rsp_after_reset", bus_if.rsp_valid, 0);
    check("fc_after_reset", fault_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
